// File: rtl/key_event_decoder.sv
// PS/2 scan-byte parser: strips E0/F0 prefixes, tracks shift and the held key,
// counts new presses and queues decoded events in a first-word-fall-through FIFO.
module key_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned CNT_SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic [3:0]       ev_flags,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             ev_overflow,
  input  logic             clr_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned EW = 12;

  localparam logic [7:0] B_EXT  = 8'hE0;
  localparam logic [7:0] B_BRK  = 8'hF0;
  localparam logic [7:0] K_LSFT = 8'h12;
  localparam logic [7:0] K_RSFT = 8'h59;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t state, state_next;

  logic          emit, ev_ext, ev_brk;
  logic          is_lsft, is_rsft, is_mod;
  logic          held_ext, held_match;
  logic          sft_l, sft_r, sft_l_next, sft_r_next, sft_flag;
  logic          rep, new_press, release_held;
  logic [EW-1:0] ev_word;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill;
  logic          full, pop, push_ok, drop;
  logic [EW-1:0] head;

  // Parser state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Prefix parser: next state and event strobe with ext/brk qualifiers
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    if (in_valid) begin
      unique case (state)
        S_IDLE: begin
          if (in_data == B_EXT)      state_next = S_EXT;
          else if (in_data == B_BRK) state_next = S_BRK;
          else                       emit = 1'b1;
        end
        S_EXT: begin
          if (in_data == B_BRK)      state_next = S_EXT_BRK;
          else if (in_data == B_EXT) state_next = S_EXT;
          else begin
            emit       = 1'b1;
            ev_ext     = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_BRK: begin
          if (in_data == B_EXT)      state_next = S_EXT_BRK;
          else if (in_data == B_BRK) state_next = S_BRK;
          else begin
            emit       = 1'b1;
            ev_brk     = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (in_data == B_EXT || in_data == B_BRK) state_next = S_EXT_BRK;
          else begin
            emit       = 1'b1;
            ev_ext     = 1'b1;
            ev_brk     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Event classification: modifier detection, shift flag, repeat and held-key matching
  always_comb begin
    is_lsft      = emit && !ev_ext && (in_data == K_LSFT);
    is_rsft      = emit && !ev_ext && (in_data == K_RSFT);
    is_mod       = is_lsft || is_rsft;
    sft_l_next   = is_lsft ? !ev_brk : sft_l;
    sft_r_next   = is_rsft ? !ev_brk : sft_r;
    // A shift key's own press or release does not flag itself as shifted
    sft_flag     = (sft_l || sft_r) && (sft_l_next || sft_r_next);
    held_match   = key_held && (held_ext == ev_ext) && (held_code == in_data);
    rep          = emit && !ev_brk && !is_mod && held_match;
    new_press    = emit && !ev_brk && !is_mod && !held_match;
    release_held = emit && ev_brk && !is_mod && held_match;
    ev_word      = {rep, sft_flag, ev_ext, ev_brk, in_data};
  end

  // Shift, held-key and press-counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      sft_l       <= 1'b0;
      sft_r       <= 1'b0;
      key_held    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= '0;
    end else begin
      sft_l <= sft_l_next;
      sft_r <= sft_r_next;
      if (new_press) begin
        key_held  <= 1'b1;
        held_code <= in_data;
        held_ext  <= ev_ext;
        if (!((CNT_SAT != 0) && (&press_count))) press_count <= press_count + CNT_W'(1);
      end else if (release_held) begin
        key_held <= 1'b0;
      end
    end
  end

  // FIFO control: a full FIFO still accepts when the head is popped in the same cycle
  always_comb begin
    full    = (fill == FW'(FIFO_DEPTH));
    pop     = ev_valid && ev_ready;
    push_ok = emit && (!full || pop);
    drop    = emit && full && !pop;
    head    = mem[rd_ptr];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + FW'(push_ok) - FW'(pop);
      if (drop)         ev_overflow <= 1'b1;
      else if (clr_ovf) ev_overflow <= 1'b0;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ev_word;
  end

  assign ev_valid = (fill != '0);
  assign ev_code  = ev_valid ? head[7:0]  : 8'h00;
  assign ev_flags = ev_valid ? head[11:8] : 4'h0;

endmodule
